// File: rtl/dip_switch_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dip_switch_scan_ctrl
//   Synchronises and debounces a 64-bit active-low DIP switch bank and holds a
//   stable snapshot for the CPU. Raises a level interrupt whenever the
//   debounced snapshot changes. A control/status word lets software enable
//   the interrupt and acknowledge it (write-1-to-clear).
//
// Ports
//   clk      : system clock
//   reset    : synchronous active-high reset
//   Addr     : bridge address, only Addr[3:2] decoded
//   WE       : bridge write enable for this device
//   WD       : bridge write data
//   In0..In7 : raw switch groups, active-low, asynchronous to clk
//   RD       : read data, combinational on Addr[3:2]
//   IRQ      : interrupt request, pending & enable
// -----------------------------------------------------------------------------
module dip_switch_scan_ctrl #(
  parameter int               CNT_W    = 20,
  parameter logic [CNT_W-1:0] DEBOUNCE = CNT_W'(1000000)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  input  logic [7:0]  In0,
  input  logic [7:0]  In1,
  input  logic [7:0]  In2,
  input  logic [7:0]  In3,
  input  logic [7:0]  In4,
  input  logic [7:0]  In5,
  input  logic [7:0]  In6,
  input  logic [7:0]  In7,
  output logic [31:0] RD,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] LP_LAST = DEBOUNCE - CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

  state_t           r_state;
  logic [63:0]      r_sync1;
  logic [63:0]      r_sync2;
  logic [63:0]      r_cand;
  logic [63:0]      r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_enable;

  logic [63:0] w_raw;
  logic        w_csr_wr;
  logic        w_window_done;
  logic        w_commit;
  logic        w_unused;

  assign w_raw    = {In7, In6, In5, In4, In3, In2, In1, In0};
  assign w_csr_wr = WE && (Addr[3:2] == 2'b10);

  // The window closes when the candidate has held for the full count; it only
  // commits if the candidate actually differs from the current snapshot.
  assign w_window_done = (r_state == ST_SETTLE) && (r_sync2 == r_cand) &&
                         (r_cnt == LP_LAST);
  assign w_commit      = w_window_done && (r_cand != r_stable);

  assign w_unused = ^{Addr[31:4], Addr[1:0], WD[31:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_cand    <= '1;
      r_stable  <= '1;
      r_cnt     <= '0;
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_enable  <= 1'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;

      case (r_state)
        ST_IDLE: begin
          if (r_sync2 != r_stable) begin
            r_cand  <= r_sync2;
            r_cnt   <= '0;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_sync2 != r_cand) begin
            // Any bounce restarts the window on the new value.
            r_cand <= r_sync2;
            r_cnt  <= '0;
          end else if (w_window_done) begin
            if (w_commit) r_stable <= r_cand;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_csr_wr) begin
        r_enable <= WD[1];
        if (WD[0]) r_pending <= 1'b0;
      end
      // Placed after the clear so a same-edge commit wins.
      if (w_commit) r_pending <= 1'b1;
    end
  end

  always_comb begin
    RD = 32'h0;
    case (Addr[3:2])
      2'b00:   RD = ~r_stable[63:32];
      2'b01:   RD = ~r_stable[31:0];
      2'b10:   RD = {30'b0, r_enable, r_pending};
      default: RD = 32'h0;
    endcase
  end

  assign IRQ = r_pending & r_enable;

endmodule

// File: tb/tb_dip_switch_scan_ctrl.sv
module tb_dip_switch_scan_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [7:0]  sw [8];
  logic [31:0] RD;
  logic        IRQ;

  int checks   = 0;
  int failures = 0;

  // Reference model state, expressed in time: a debounce window opened at
  // edge m_ws commits at edge m_ws + D if the observed value never moved.
  logic [63:0] m_stable, m_cand, m_d1, m_d2;
  logic        m_pend, m_en, m_win;
  int          m_ws, m_edge;

  always #5 clk = ~clk;

  dip_switch_scan_ctrl #(.CNT_W(20), .DEBOUNCE(20'd4)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .WD(WD),
    .In0(sw[0]), .In1(sw[1]), .In2(sw[2]), .In3(sw[3]),
    .In4(sw[4]), .In5(sw[5]), .In6(sw[6]), .In7(sw[7]),
    .RD(RD), .IRQ(IRQ)
  );

  function automatic logic [63:0] raw_vec();
    return {sw[7], sw[6], sw[5], sw[4], sw[3], sw[2], sw[1], sw[0]};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    case (a[3:2])
      2'b00:   return ~m_stable[63:32];
      2'b01:   return ~m_stable[31:0];
      2'b10:   return {30'b0, m_en, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] seen;
    logic        commit;
    commit = 1'b0;
    if (reset) begin
      m_stable = '1; m_cand = '1; m_d1 = '1; m_d2 = '1;
      m_pend = 1'b0; m_en = 1'b0; m_win = 1'b0;
    end else begin
      seen = m_d2;
      if (!m_win) begin
        if (seen != m_stable) begin m_win = 1'b1; m_ws = m_edge; m_cand = seen; end
      end else if (seen != m_cand) begin
        m_ws = m_edge; m_cand = seen;
      end else if (m_edge - m_ws == D) begin
        if (m_cand != m_stable) begin m_stable = m_cand; commit = 1'b1; end
        m_win = 1'b0;
      end
      if (WE && Addr[3:2] == 2'b10) begin
        m_en = WD[1];
        if (WD[0]) m_pend = 1'b0;
      end
      if (commit) m_pend = 1'b1;
      m_d2 = m_d1;
      m_d1 = raw_vec();
    end
    m_edge++;
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("rd_model", RD, exp_rd(Addr));
    chk("irq_model", {31'b0, IRQ}, {31'b0, m_pend & m_en});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(name, RD, exp);
  endtask

  initial begin
    m_edge = 0; m_ws = 0;
    reset = 1'b1; Addr = 32'h0; WE = 1'b0; WD = 32'h0;
    for (int i = 0; i < 8; i++) sw[i] = 8'hFF;
    @(negedge clk);
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // Reset state
    peek("rst_hi", 32'h0, 32'h0);
    peek("rst_lo", 32'h4, 32'h0);
    peek("rst_status", 32'h8, 32'h0);
    chk("rst_irq", {31'b0, IRQ}, 32'h0);

    // Single switch on, latency D+2 after the sampling edge
    Addr = 32'h4;
    sw[0] = 8'hFE;
    ticks(6);
    chk("lat_before", RD, 32'h0);
    tick();
    chk("lat_commit", RD, 32'h1);
    peek("lat_status", 32'h8, 32'h1);
    chk("lat_irq_off", {31'b0, IRQ}, 32'h0);

    // Enable and clear, then bounce In7 bit0
    WE = 1'b1; WD = 32'h3; Addr = 32'h8;
    tick();
    WE = 1'b0;
    chk("en_status", RD, 32'h2);
    Addr = 32'h0;
    for (int k = 0; k < 10; k++) begin
      sw[7] = sw[7] ^ 8'h01;
      ticks(2);
    end
    peek("bounce_nocommit", 32'h8, 32'h2);
    Addr = 32'h0;
    sw[7] = 8'hFE;
    ticks(6);
    chk("bounce_before", RD, 32'h0);
    chk("bounce_irq_before", {31'b0, IRQ}, 32'h0);
    tick();
    chk("bounce_commit", RD, 32'h01000000);
    chk("bounce_irq", {31'b0, IRQ}, 32'h1);

    // Acknowledge, then a write to a non-CSR offset
    WE = 1'b1; WD = 32'h3; Addr = 32'h8;
    tick();
    WE = 1'b0;
    chk("ack_status", RD, 32'h2);
    chk("ack_irq", {31'b0, IRQ}, 32'h0);
    WE = 1'b1; WD = 32'h3; Addr = 32'h0;
    tick();
    WE = 1'b0;
    peek("ignored_wr", 32'h8, 32'h2);

    // Commit and clear on the same edge: set wins
    sw[7] = 8'hFF;
    ticks(6);
    WE = 1'b1; WD = 32'h3; Addr = 32'h8;
    tick();
    WE = 1'b0;
    chk("same_edge_status", RD, 32'h3);
    chk("same_edge_irq", {31'b0, IRQ}, 32'h1);
    peek("same_edge_hi", 32'h0, 32'h0);

    // Reset in the middle of a debounce window
    WE = 1'b1; WD = 32'h3; Addr = 32'h8;
    tick();
    WE = 1'b0;
    sw[1] = 8'hFE;
    ticks(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    peek("mid_rst_lo", 32'h4, 32'h0);
    peek("mid_rst_hi", 32'h0, 32'h0);
    peek("mid_rst_status", 32'h8, 32'h0);
    chk("mid_rst_irq", {31'b0, IRQ}, 32'h0);
    ticks(6);
    chk("redeb_before", RD, 32'h0);
    tick();
    chk("redeb_pending", RD, 32'h1);
    peek("redeb_lo", 32'h4, 32'h00000101);

    // Randomised phase
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) sw[r / 8][r % 8] = ~sw[r / 8][r % 8];
      Addr  = $urandom;
      WE    = ($urandom_range(0, 9) == 0);
      WD    = $urandom;
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; WE = 1'b0;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
